mvm_rx_framer: RTL

MVM_RX_FRAMER -- requirements
Module: mvm_rx_framer

---
 rtl/mvm_uart_pkg.sv | 24 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 rtl/mvm_rx_framer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mvm_uart_pkg.sv
// Shared constants, frame-size helper and bit-FSM state type for the MVM UART receive path.
package mvm_uart_pkg;

    localparam int DEF_CLOCKS_PER_PULSE = 10;
    localparam int DEF_BITS_PER_WORD    = 8;
    localparam int DEF_R                = 2;
    localparam int DEF_C                = 2;
    localparam int DEF_W_X              = 4;
    localparam int DEF_W_K              = 4;
    localparam int DEF_TIMEOUT_PULSES   = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Number of UART words needed to carry total_bits, rounded up.
    function automatic int num_words(input int total_bits, input int bits_per_word);
        return (total_bits + bits_per_word - 1) / bits_per_word;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop synchronizer, start-glitch rejection, LSB-first data, stop-bit check.
// Exposes rx_idle only when MVM_RX_TIMEOUT_EN is defined.
module uart_rx
    import mvm_uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] word_data,
    output logic                     word_valid,
`ifdef MVM_RX_TIMEOUT_EN
    output logic                     rx_idle,
`endif
    output logic                     frame_err
);

    localparam int CNT_W   = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int IDX_W   = $clog2(BITS_PER_WORD + 1);
    localparam int HALF_M1 = (CLOCKS_PER_PULSE / 2 > 0) ? (CLOCKS_PER_PULSE / 2 - 1) : 0;

    logic                     rx_meta_r;
    logic                     rx_sync_r;
    logic                     rx_prev_r;
    rx_state_e                state_r;
    rx_state_e                next_state_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [IDX_W-1:0]         bit_idx_r;
    logic [BITS_PER_WORD-1:0] shift_r;
    logic                     word_valid_r;
    logic                     frame_err_r;
    logic                     fall_s;
    logic                     half_hit_s;
    logic                     full_hit_s;
    logic                     last_bit_s;
    logic                     sample_s;
    logic                     shift_s;
    logic                     accept_s;
    logic                     bad_s;

    assign fall_s     = rx_prev_r & ~rx_sync_r;
    assign half_hit_s = (cnt_r == CNT_W'(HALF_M1));
    assign full_hit_s = (cnt_r == CNT_W'(CLOCKS_PER_PULSE - 1));
    assign last_bit_s = (bit_idx_r == IDX_W'(BITS_PER_WORD - 1));

    // Synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Bit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bit FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:  if (fall_s) next_state_s = ST_START; else next_state_s = ST_IDLE;
            ST_START: if (half_hit_s) next_state_s = rx_sync_r ? ST_IDLE : ST_DATA;
                      else next_state_s = ST_START;
            ST_DATA:  if (full_hit_s && last_bit_s) next_state_s = ST_STOP; else next_state_s = ST_DATA;
            ST_STOP:  if (full_hit_s) next_state_s = ST_IDLE; else next_state_s = ST_STOP;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Bit FSM output strobes.
    always_comb begin
        sample_s = 1'b0;
        shift_s  = 1'b0;
        accept_s = 1'b0;
        bad_s    = 1'b0;
        case (state_r)
            ST_IDLE:  sample_s = 1'b0;
            ST_START: sample_s = half_hit_s;
            ST_DATA: begin
                sample_s = full_hit_s;
                shift_s  = full_hit_s;
            end
            ST_STOP: begin
                sample_s = full_hit_s;
                accept_s = full_hit_s & rx_sync_r;
                bad_s    = full_hit_s & ~rx_sync_r;
            end
            default:  sample_s = 1'b0;
        endcase
    end

    // Bit timing counter, bit index and shift register; strobes registered as pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= CNT_W'(0);
            bit_idx_r    <= IDX_W'(0);
            shift_r      <= {BITS_PER_WORD{1'b0}};
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (state_r == ST_IDLE || sample_s) begin
                cnt_r <= CNT_W'(0);
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r != ST_DATA) begin
                bit_idx_r <= IDX_W'(0);
            end else if (shift_s) begin
                bit_idx_r <= bit_idx_r + IDX_W'(1);
            end else begin
                bit_idx_r <= bit_idx_r;
            end
            if (shift_s) begin
                shift_r <= {rx_sync_r, shift_r[BITS_PER_WORD-1:1]};
            end else begin
                shift_r <= shift_r;
            end
            word_valid_r <= accept_s;
            frame_err_r  <= bad_s;
        end
    end

    assign word_data  = shift_r;
    assign word_valid = word_valid_r;
    assign frame_err  = frame_err_r;
`ifdef MVM_RX_TIMEOUT_EN
    assign rx_idle    = (state_r == ST_IDLE);
`endif

endmodule

// File: rtl/mvm_rx_framer.sv
// Assembles UART words into an MVM operand frame (k matrix, x vector) with valid/ready handoff.
// Optional partial-frame timeout enabled by defining MVM_RX_TIMEOUT_EN.
module mvm_rx_framer
    import mvm_uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int R                = DEF_R,
    parameter int C                = DEF_C,
    parameter int W_X              = DEF_W_X,
    parameter int W_K              = DEF_W_K,
    parameter int TIMEOUT_PULSES   = DEF_TIMEOUT_PULSES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [R*C*W_K-1:0]   m_k,
    output logic [C*W_X-1:0]     m_x,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err_frame,
    output logic                 err_overflow
);

    localparam int K_BITS    = R * C * W_K;
    localparam int X_BITS    = C * W_X;
    localparam int NUM_WORDS = num_words(K_BITS + X_BITS, BITS_PER_WORD);
    localparam int ASM_W     = NUM_WORDS * BITS_PER_WORD;
    localparam int WC_W      = $clog2(NUM_WORDS + 1);

    logic [BITS_PER_WORD-1:0] word_s;
    logic                     word_valid_s;
    logic                     frame_err_s;
    logic [ASM_W-1:0]         asm_r;
    logic [ASM_W-1:0]         frame_s;
    logic [WC_W-1:0]          wc_r;
    logic                     last_word_s;
    logic                     frame_done_s;
    logic                     timeout_clr_s;
    logic [K_BITS-1:0]        k_r;
    logic [X_BITS-1:0]        x_r;
    logic                     m_valid_r;
    logic                     err_overflow_r;

`ifdef MVM_RX_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_PULSES * CLOCKS_PER_PULSE;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    logic            rx_idle_s;
    logic [TO_W-1:0] to_cnt_r;
    logic            partial_s;

    assign partial_s     = rx_idle_s && (wc_r != WC_W'(0)) && !word_valid_s;
    assign timeout_clr_s = partial_s && (to_cnt_r == TO_W'(TO_LIMIT - 1));

    // Counts idle clocks while a frame is only partly received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= TO_W'(0);
        end else if (partial_s && !timeout_clr_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= TO_W'(0);
        end
    end
`else
    assign timeout_clr_s = 1'b0;
`endif

    uart_rx #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .BITS_PER_WORD    (BITS_PER_WORD)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .word_data  (word_s),
        .word_valid (word_valid_s),
`ifdef MVM_RX_TIMEOUT_EN
        .rx_idle    (rx_idle_s),
`endif
        .frame_err  (frame_err_s)
    );

    assign last_word_s  = (wc_r == WC_W'(NUM_WORDS - 1));
    assign frame_done_s = word_valid_s & last_word_s;

    // Assembly contents with the incoming word dropped into its slot.
    always_comb begin
        frame_s = asm_r;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (wc_r == WC_W'(w)) begin
                frame_s[w*BITS_PER_WORD +: BITS_PER_WORD] = word_s;
            end else begin
                frame_s[w*BITS_PER_WORD +: BITS_PER_WORD] = asm_r[w*BITS_PER_WORD +: BITS_PER_WORD];
            end
        end
    end

    // Word counter and assembly register; framing errors leave the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_r  <= WC_W'(0);
            asm_r <= {ASM_W{1'b0}};
        end else if (word_valid_s) begin
            wc_r  <= last_word_s ? WC_W'(0) : (wc_r + WC_W'(1));
            asm_r <= frame_s;
        end else if (timeout_clr_s) begin
            wc_r  <= WC_W'(0);
            asm_r <= asm_r;
        end else begin
            wc_r  <= wc_r;
            asm_r <= asm_r;
        end
    end

    // Output register: a completing frame may replace data in the same clock it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r            <= {K_BITS{1'b0}};
            x_r            <= {X_BITS{1'b0}};
            m_valid_r      <= 1'b0;
            err_overflow_r <= 1'b0;
        end else if (frame_done_s && (!m_valid_r || m_ready)) begin
            k_r            <= frame_s[K_BITS-1:0];
            x_r            <= frame_s[K_BITS +: X_BITS];
            m_valid_r      <= 1'b1;
            err_overflow_r <= 1'b0;
        end else if (frame_done_s) begin
            m_valid_r      <= m_valid_r;
            err_overflow_r <= 1'b1;
        end else if (m_valid_r && m_ready) begin
            m_valid_r      <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            m_valid_r      <= m_valid_r;
            err_overflow_r <= 1'b0;
        end
    end

    assign m_k          = k_r;
    assign m_x          = x_r;
    assign m_valid      = m_valid_r;
    assign err_frame    = frame_err_s;
    assign err_overflow = err_overflow_r;

endmodule
